// File: rtl/mem_arb.sv
// Two-requester memory arbiter: fetch and data ports share one read slot and
// one write slot per cycle, round-robin on contention, fixed 2-cycle read return.
module mem_arb (
  input  logic        clk,
  input  logic        reset,
  input  logic        f_req,
  input  logic [15:1] f_addr,
  input  logic        f_flush,
  output logic        f_gnt,
  output logic        f_valid,
  output logic [15:0] f_data,
  input  logic        d_req,
  input  logic        d_we,
  input  logic [15:1] d_addr,
  input  logic [15:0] d_wdata,
  output logic        d_gnt,
  output logic        d_valid,
  output logic [15:0] d_data,
  output logic [15:1] m_raddr,
  input  logic [15:0] m_rdata,
  output logic        m_wen,
  output logic [15:1] m_waddr,
  output logic [15:0] m_wdata
);

  localparam int   STAGES = 2;
  localparam logic OWN_F  = 1'b0;
  localparam logic OWN_D  = 1'b1;

  logic              last_d;
  logic [STAGES:1]   vld_pipe;
  logic [STAGES:1]   own_pipe;
  logic              d_rd_gnt;
  logic              rd_gnt;

  // On contention the requester that did not win last time gets the slot.
  always_comb begin
    f_gnt = 1'b0;
    d_gnt = 1'b0;
    if (!reset) begin
      if (f_req && d_req) begin
        f_gnt = last_d;
        d_gnt = !last_d;
      end else begin
        f_gnt = f_req;
        d_gnt = d_req;
      end
    end
  end

  always_comb begin
    d_rd_gnt = d_gnt & !d_we;
    rd_gnt   = f_gnt | d_rd_gnt;
    m_raddr  = d_rd_gnt ? d_addr : f_addr;
    m_wen    = d_gnt & d_we;
    m_waddr  = d_addr;
    m_wdata  = d_wdata;
  end

  // Flush kills fetch entries already in flight and the fetch granted now.
  always_ff @(posedge clk) begin
    if (reset) begin
      last_d   <= OWN_D;
      vld_pipe <= '0;
      own_pipe <= '0;
    end else begin
      if (f_gnt || d_gnt)
        last_d <= d_gnt;
      vld_pipe[1] <= rd_gnt & !(f_flush & f_gnt);
      own_pipe[1] <= d_rd_gnt ? OWN_D : OWN_F;
      vld_pipe[2] <= vld_pipe[1] & !(f_flush & (own_pipe[1] == OWN_F));
      own_pipe[2] <= own_pipe[1];
    end
  end

  always_comb begin
    f_valid = !reset & vld_pipe[STAGES] & (own_pipe[STAGES] == OWN_F);
    d_valid = !reset & vld_pipe[STAGES] & (own_pipe[STAGES] == OWN_D);
    f_data  = f_valid ? m_rdata : 16'h0000;
    d_data  = d_valid ? m_rdata : 16'h0000;
  end

endmodule

// File: tb/tb_mem_arb.sv
// Directed bench for mem_arb with a 2-cycle-latency memory model.
module tb_mem_arb;

  logic        clk;
  logic        reset;
  logic        f_req;
  logic [15:1] f_addr;
  logic        f_flush;
  logic        f_gnt;
  logic        f_valid;
  logic [15:0] f_data;
  logic        d_req;
  logic        d_we;
  logic [15:1] d_addr;
  logic [15:0] d_wdata;
  logic        d_gnt;
  logic        d_valid;
  logic [15:0] d_data;
  logic [15:1] m_raddr;
  logic [15:0] m_rdata;
  logic        m_wen;
  logic [15:1] m_waddr;
  logic [15:0] m_wdata;

  int tests;
  int fails;

  logic [15:0] mem [0:32767];
  logic [15:1] raddr_q;
  logic [15:0] rdata_q;

  mem_arb dut (
    .clk(clk), .reset(reset),
    .f_req(f_req), .f_addr(f_addr), .f_flush(f_flush),
    .f_gnt(f_gnt), .f_valid(f_valid), .f_data(f_data),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_gnt(d_gnt), .d_valid(d_valid), .d_data(d_data),
    .m_raddr(m_raddr), .m_rdata(m_rdata), .m_wen(m_wen),
    .m_waddr(m_waddr), .m_wdata(m_wdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Address registered at the grant edge, data registered one edge later.
  always @(posedge clk) begin
    if (m_wen) mem[m_waddr] <= m_wdata;
    raddr_q <= m_raddr;
    rdata_q <= mem[raddr_q];
  end
  assign m_rdata = rdata_q;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    f_req = 0; f_flush = 0; f_addr = '0;
    d_req = 0; d_we = 0; d_addr = '0; d_wdata = '0;
  endtask

  task automatic pulse_reset();
    idle_inputs();
    reset = 1;
    tick();
    reset = 0;
  endtask

  task automatic test_reset();
    reset = 1; f_req = 1; d_req = 1; d_we = 1; f_flush = 0;
    f_addr = 15'h0010; d_addr = 15'h0020; d_wdata = 16'h1234;
    tick(); tick();
    #3;
    tests++; if ({f_gnt, d_gnt} !== 2'b00) begin fails++; $display("FAIL reset gnt: got %b want 00", {f_gnt, d_gnt}); end
    tests++; if (m_wen !== 1'b0) begin fails++; $display("FAIL reset m_wen: got %b want 0", m_wen); end
    tests++; if ({f_valid, d_valid} !== 2'b00) begin fails++; $display("FAIL reset valid: got %b want 00", {f_valid, d_valid}); end
    tests++; if ({f_data, d_data} !== 32'h0) begin fails++; $display("FAIL reset data: got %h want 0", {f_data, d_data}); end
    tick();
    reset = 0;
    idle_inputs();
  endtask

  task automatic test_fetch();
    logic [2:0] exp_vld;
    exp_vld = 3'b100;
    for (int c = 0; c < 3; c++) begin
      f_req = (c == 0); f_addr = 15'h0010;
      #3;
      tests++; if (f_gnt !== (c == 0)) begin fails++; $display("FAIL fetch f_gnt c%0d: got %b want %b", c, f_gnt, (c == 0)); end
      tests++; if (f_valid !== exp_vld[c] || f_data !== (exp_vld[c] ? 16'h3EC3 : 16'h0000))
        begin fails++; $display("FAIL fetch resp c%0d: got %b/%h want %b/%h", c, f_valid, f_data, exp_vld[c], exp_vld[c] ? 16'h3EC3 : 16'h0000); end
      if (c == 0) begin
        tests++; if (m_raddr !== 15'h0010) begin fails++; $display("FAIL fetch m_raddr: got %h want 0010", m_raddr); end
      end
      tick();
    end
    idle_inputs();
  endtask

  task automatic test_contention();
    logic [1:0]  exp_gnt [0:5];
    logic [1:0]  exp_vld [0:5];
    logic [15:0] exp_fd, exp_dd;
    exp_gnt = '{2'b10, 2'b01, 2'b10, 2'b01, 2'b00, 2'b00};
    exp_vld = '{2'b00, 2'b00, 2'b10, 2'b01, 2'b10, 2'b01};
    for (int c = 0; c < 6; c++) begin
      f_req = (c < 4); d_req = (c < 4); d_we = 0;
      f_addr = 15'h0020; d_addr = 15'h0030;
      #3;
      exp_fd = exp_vld[c][1] ? 16'h1111 : 16'h0000;
      exp_dd = exp_vld[c][0] ? 16'h2222 : 16'h0000;
      tests++; if ({f_gnt, d_gnt} !== exp_gnt[c]) begin fails++; $display("FAIL contention gnt c%0d: got %b want %b", c, {f_gnt, d_gnt}, exp_gnt[c]); end
      tests++; if ({f_valid, d_valid} !== exp_vld[c]) begin fails++; $display("FAIL contention valid c%0d: got %b want %b", c, {f_valid, d_valid}, exp_vld[c]); end
      tests++; if (f_data !== exp_fd || d_data !== exp_dd) begin fails++; $display("FAIL contention data c%0d: got %h/%h want %h/%h", c, f_data, d_data, exp_fd, exp_dd); end
      if (exp_gnt[c] == 2'b01) begin
        tests++; if (m_raddr !== 15'h0030) begin fails++; $display("FAIL contention m_raddr c%0d: got %h want 0030", c, m_raddr); end
      end
      tick();
    end
    idle_inputs();
  endtask

  task automatic test_write_read();
    d_req = 1; d_we = 1; d_addr = 15'h0100; d_wdata = 16'hBEEF;
    #3;
    tests++; if (d_gnt !== 1'b1 || m_wen !== 1'b1) begin fails++; $display("FAIL wr gnt/wen: got %b/%b want 1/1", d_gnt, m_wen); end
    tests++; if (m_waddr !== 15'h0100 || m_wdata !== 16'hBEEF) begin fails++; $display("FAIL wr port: got %h/%h want 0100/beef", m_waddr, m_wdata); end
    tick();
    d_we = 0; d_wdata = 16'h0000;
    #3;
    tests++; if (d_gnt !== 1'b1 || m_wen !== 1'b0) begin fails++; $display("FAIL rd gnt/wen: got %b/%b want 1/0", d_gnt, m_wen); end
    tests++; if (m_raddr !== 15'h0100) begin fails++; $display("FAIL rd m_raddr: got %h want 0100", m_raddr); end
    tick();
    d_req = 0;
    #3;
    tests++; if (d_valid !== 1'b0 || m_wen !== 1'b0) begin fails++; $display("FAIL wr no-valid: got %b/%b want 0/0", d_valid, m_wen); end
    tick();
    #3;
    tests++; if (d_valid !== 1'b1 || d_data !== 16'hBEEF) begin fails++; $display("FAIL wr readback: got %b/%h want 1/beef", d_valid, d_data); end
    tick();
    idle_inputs();
  endtask

  task automatic test_flush();
    logic [4:0] exp_vld;
    exp_vld = 5'b10000;
    for (int c = 0; c < 5; c++) begin
      f_req = (c < 3); f_flush = (c == 1);
      f_addr = (c == 1) ? 15'h0020 : 15'h0010;
      #3;
      tests++; if (f_gnt !== (c < 3)) begin fails++; $display("FAIL flush f_gnt c%0d: got %b want %b", c, f_gnt, (c < 3)); end
      if (c >= 2) begin
        tests++; if (f_valid !== exp_vld[c] || f_data !== (exp_vld[c] ? 16'h3EC3 : 16'h0000))
          begin fails++; $display("FAIL flush resp c%0d: got %b/%h want %b/%h", c, f_valid, f_data, exp_vld[c], exp_vld[c] ? 16'h3EC3 : 16'h0000); end
      end
      tick();
    end
    idle_inputs();
  endtask

  task automatic test_mixed_flush();
    d_req = 1; d_we = 0; d_addr = 15'h0030;
    tick();
    d_req = 0; f_req = 1; f_addr = 15'h0010; f_flush = 1;
    #3;
    tests++; if (f_gnt !== 1'b1) begin fails++; $display("FAIL mixflush f_gnt: got %b want 1", f_gnt); end
    tick();
    f_req = 0; f_flush = 0;
    #3;
    tests++; if (d_valid !== 1'b1 || d_data !== 16'h2222) begin fails++; $display("FAIL mixflush d resp: got %b/%h want 1/2222", d_valid, d_data); end
    tests++; if (f_valid !== 1'b0) begin fails++; $display("FAIL mixflush f_valid c2: got %b want 0", f_valid); end
    tick();
    #3;
    tests++; if (f_valid !== 1'b0 || d_valid !== 1'b0) begin fails++; $display("FAIL mixflush c3 valid: got %b/%b want 0/0", f_valid, d_valid); end
    tick();
    idle_inputs();
  endtask

  task automatic test_reset_mid();
    f_req = 1; f_addr = 15'h0010;
    #3;
    tests++; if (f_gnt !== 1'b1) begin fails++; $display("FAIL rstmid f_gnt c0: got %b want 1", f_gnt); end
    tick();
    f_req = 0; d_req = 1; d_we = 0; d_addr = 15'h0030; reset = 1;
    #3;
    tests++; if (d_gnt !== 1'b0) begin fails++; $display("FAIL rstmid d_gnt c1: got %b want 0", d_gnt); end
    tests++; if ({f_valid, d_valid} !== 2'b00) begin fails++; $display("FAIL rstmid valid c1: got %b want 00", {f_valid, d_valid}); end
    tick();
    reset = 0; d_req = 0;
    for (int c = 2; c < 4; c++) begin
      #3;
      tests++; if ({f_valid, d_valid} !== 2'b00 || {f_data, d_data} !== 32'h0)
        begin fails++; $display("FAIL rstmid valid c%0d: got %b/%h want 00/0", c, {f_valid, d_valid}, {f_data, d_data}); end
      tick();
    end
    f_req = 1; d_req = 1; f_addr = 15'h0010; d_addr = 15'h0030;
    #3;
    tests++; if ({f_gnt, d_gnt} !== 2'b10) begin fails++; $display("FAIL rstmid first contention: got %b want 10", {f_gnt, d_gnt}); end
    tick();
    idle_inputs();
  endtask

  initial begin
    tests = 0; fails = 0;
    for (int i = 0; i < 32768; i++) mem[i] = 16'h0000;
    mem[15'h0010] = 16'h3EC3;
    mem[15'h0020] = 16'h1111;
    mem[15'h0030] = 16'h2222;
    idle_inputs();
    reset = 1;
    test_reset();
    test_fetch();
    pulse_reset();
    test_contention();
    test_write_read();
    test_flush();
    test_mixed_flush();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
